mem_sequencer: RTL and testbench
================================

# mem_sequencer

Command-side initiator for `memory_module`: drives its address, read/write-code and `IN` ports to load operand rows into banks A and B, sum each row into the SUM bank, then stream the SUM contents out for display. It sits between the keypad/entry logic (byte stream in) and the LCD driver (byte stream out), replacing hand-driven address/rw lines with a single `start`-triggered sequence.

## Interface
- `N`, 4: rows processed per run; legal 1..31 (address 31 is reserved as scratch).
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse begins a run; ignored while `busy`=1.
- `in_data` in 8: operand byte.
- `in_valid` in 1 / `in_ready` out 1: operand handshake; a byte transfers on a cycle with both high.
- `IN` out 8: shared write data to all memories.
- `add1`,`add2`,`add3` out 5: A-bank addresses; `bdd1`,`bdd2`,`bdd3` out 5: B-bank addresses; `cond` out 5: SUM address.
- `arw`,`brw`,`crw` out 2: bank codes, 11=read, 10=write, 00=idle.
- `a_1`,`a_2`,`a_3`,`b_1`,`b_2`,`b_3`,`dis_out` in 8: memory read data.
- `out_data` out 8 / `out_valid` out 1 / `out_ready` in 1: display stream; transfer on both high.
- `busy` out 1: run in progress. `done` out 1: one-cycle pulse at run end.

## Operation
- States: IDLE, LOAD, RD_REQ, RD_WAIT, SUM_WR, DISP_REQ, DISP_WAIT, DISP_OUT, DONE.
- IDLE: all rw codes 00, `in_ready`=0. `start` leads to LOAD with row r=0 and slot s=0. `busy` rises the next cycle.
- LOAD: `in_ready`=1. Each accepted byte goes to slot s of row r. Slot order is a1,a2,a3,b1,b2,b3.
  - Write is issued in the same cycle as acceptance.
  - Target bank code = 10. Target address = r. The two sibling addresses in that bank = 31. Other banks = 00. `IN`=`in_data`.
  - A cycle with no transfer drives all codes 00.
  - After slot 5 of row N-1 the block moves to RD_REQ with r=0.
- RD_REQ: `arw`=`brw`=11; all six addresses = r. One cycle, then RD_WAIT.
- RD_WAIT: codes 00. Memory data is valid this cycle. Capture sum = a_1+a_2+a_3+b_1+b_2+b_3, computed at 11 bits and then reduced to 8 bits per Configuration. Go to SUM_WR.
- SUM_WR: `crw`=10, `cond`=r, `IN`=sum. One cycle.
  - If r<N-1: r++ and return to RD_REQ.
  - Otherwise: r=0 and go to DISP_REQ.
- DISP_REQ: `crw`=11, `cond`=r. One cycle, then DISP_WAIT.
- DISP_WAIT: capture `dis_out` into `out_data`, then DISP_OUT.
- DISP_OUT: `out_valid`=1, `out_data` held stable until `out_ready`.
  - On transfer with r<N-1: r++ and return to DISP_REQ.
  - On transfer otherwise: go to DONE.
- DONE: `done`=1 for one cycle, `busy`=0 from the next cycle, then IDLE.
- Unused address outputs hold their last value; their bank code is 00.

## Timing
- Reset values: all addresses 0, all codes 00, `IN`=0, `out_data`=0, `in_ready`=`out_valid`=`busy`=`done`=0, state IDLE.
- Reset asserted mid-run returns to IDLE immediately. Memory contents are not touched by this block, and no partial run resumes.
- Memory read latency is fixed at one cycle: data is valid the cycle after the read code.
- Loading with back-to-back `in_valid` takes 6N cycles.
- Compute takes 3 cycles per row: RD_REQ, RD_WAIT, SUM_WR.
- Display takes 3 cycles per row with `out_ready` held high.
- `start` asserted during `busy` and in the DONE cycle is dropped.
- `in_valid` outside LOAD is ignored.

## Configuration
- `MEM_SEQ_SAT_EN` defined: an 11-bit sum above 255 stores 255.
- `MEM_SEQ_SAT_EN` undefined: the low 8 bits are stored (wrap modulo 256).

## Test plan
- N=2, stream bytes 1..12 → SUM[0]=21, SUM[1]=57. Output stream 21, 57, then `done` pulses once.
- The load of byte a2=2 at row 0 → `arw`=10, `add2`=0, `add1`=`add3`=31, `brw`=`crw`=00, `IN`=2.
- All twelve bytes 0xFF → stored 0xFA without the macro, 0xFF with `MEM_SEQ_SAT_EN`.
- Hold `out_ready` low 3 cycles in DISP_OUT → `out_valid`=1 and `out_data` unchanged throughout. Transfer occurs on the cycle `out_ready` rises.
- Pulse `start` at LOAD byte 3, then pull `rst` low → second start ignored. After reset all outputs return to their reset values and the state is IDLE. A fresh run completes with correct sums.
- `in_valid` toggling 1,0,1 → writes only on transfer cycles, and all codes 00 on the idle cycle.

Source files
------------

// File: rtl/mem_sequencer_if.sv
// Bus bundle between mem_sequencer, memory_module and the byte streams.
// master = sequencer side, slave = memory/entry/display side.
interface mem_sequencer_if;
   logic       start;
   logic       busy;
   logic       done;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] IN;
   logic [4:0] add1, add2, add3;
   logic [4:0] bdd1, bdd2, bdd3;
   logic [4:0] cond;
   logic [1:0] arw, brw, crw;
   logic [7:0] a_1, a_2, a_3;
   logic [7:0] b_1, b_2, b_3;
   logic [7:0] dis_out;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;

   modport master (
      input  start, in_data, in_valid,
      input  a_1, a_2, a_3, b_1, b_2, b_3,
      input  dis_out, out_ready,
      output busy, done, in_ready, IN,
      output add1, add2, add3, bdd1, bdd2, bdd3,
      output cond, arw, brw, crw,
      output out_data, out_valid
   );

   modport slave (
      output start, in_data, in_valid,
      output a_1, a_2, a_3, b_1, b_2, b_3,
      output dis_out, out_ready,
      input  busy, done, in_ready, IN,
      input  add1, add2, add3, bdd1, bdd2, bdd3,
      input  cond, arw, brw, crw,
      input  out_data, out_valid
   );
endinterface

// File: rtl/mem_sequencer.sv
// Load A/B rows, sum each row into SUM, stream SUM out.
// MEM_SEQ_SAT_EN: saturate row sums at 255 instead of wrapping.
module mem_sequencer #(
   parameter int N = 4
) (
   input logic       clk,
   input logic       rst,
   mem_sequencer_if.master m
);
   typedef enum logic [3:0] {
      S_IDLE, S_LOAD, S_RD_REQ, S_RD_WAIT, S_SUM_WR,
      S_DISP_REQ, S_DISP_WAIT, S_DISP_OUT, S_DONE
   } state_t;

   localparam logic [4:0] LAST = 5'(N - 1);
   localparam logic [4:0] SCR  = 5'd31;
   localparam logic [1:0] RD   = 2'b11;
   localparam logic [1:0] WR   = 2'b10;

   state_t          r_state, w_next;
   logic [4:0]      r_row, w_row;
   logic [2:0]      r_slot, w_slot;
   logic [2:0]      w_bi;
   logic [7:0]      r_sum, w_sum;
   logic [7:0]      r_out, w_out;
   logic [7:0]      r_in, w_in;
   logic [4:0]      r_cond, w_cond;
   logic [2:0][4:0] r_add, w_add;
   logic [2:0][4:0] r_bdd, w_bdd;
   logic [1:0]      w_arw, w_brw, w_crw;
   logic            w_in_ready, w_out_valid, w_done;
   logic [7:0]      w_row_sum;

`ifdef MEM_SEQ_SAT_EN
   logic [10:0] w_sum11;
   assign w_sum11 = 11'(m.a_1) + 11'(m.a_2) + 11'(m.a_3)
                  + 11'(m.b_1) + 11'(m.b_2) + 11'(m.b_3);
   assign w_row_sum = (w_sum11 > 11'd255) ? 8'hFF : w_sum11[7:0];
`else
   assign w_row_sum = m.a_1 + m.a_2 + m.a_3
                    + m.b_1 + m.b_2 + m.b_3;
`endif

   assign w_bi = r_slot - 3'd3;

   always_comb begin
      w_next      = r_state;
      w_row       = r_row;
      w_slot      = r_slot;
      w_sum       = r_sum;
      w_out       = r_out;
      w_in        = r_in;
      w_cond      = r_cond;
      w_add       = r_add;
      w_bdd       = r_bdd;
      w_arw       = 2'b00;
      w_brw       = 2'b00;
      w_crw       = 2'b00;
      w_in_ready  = 1'b0;
      w_out_valid = 1'b0;
      w_done      = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (m.start) begin
               w_next = S_LOAD;
               w_row  = '0;
               w_slot = '0;
            end
         end
         S_LOAD: begin
            w_in_ready = 1'b1;
            if (m.in_valid) begin
               w_in = m.in_data;
               // siblings point at scratch row 31 so they never clobber data
               if (r_slot < 3'd3) begin
                  w_arw = WR;
                  for (int i = 0; i < 3; i++)
                     w_add[i] = (r_slot == 3'(i)) ? r_row : SCR;
               end else begin
                  w_brw = WR;
                  for (int i = 0; i < 3; i++)
                     w_bdd[i] = (w_bi == 3'(i)) ? r_row : SCR;
               end
               if (r_slot == 3'd5) begin
                  w_slot = '0;
                  if (r_row == LAST) begin
                     w_row  = '0;
                     w_next = S_RD_REQ;
                  end else begin
                     w_row = r_row + 5'd1;
                  end
               end else begin
                  w_slot = r_slot + 3'd1;
               end
            end
         end
         S_RD_REQ: begin
            w_arw  = RD;
            w_brw  = RD;
            w_add  = {3{r_row}};
            w_bdd  = {3{r_row}};
            w_next = S_RD_WAIT;
         end
         S_RD_WAIT: begin
            w_sum  = w_row_sum;
            w_next = S_SUM_WR;
         end
         S_SUM_WR: begin
            w_crw  = WR;
            w_cond = r_row;
            w_in   = r_sum;
            if (r_row < LAST) begin
               w_row  = r_row + 5'd1;
               w_next = S_RD_REQ;
            end else begin
               w_row  = '0;
               w_next = S_DISP_REQ;
            end
         end
         S_DISP_REQ: begin
            w_crw  = RD;
            w_cond = r_row;
            w_next = S_DISP_WAIT;
         end
         S_DISP_WAIT: begin
            w_out  = m.dis_out;
            w_next = S_DISP_OUT;
         end
         S_DISP_OUT: begin
            w_out_valid = 1'b1;
            if (m.out_ready) begin
               if (r_row < LAST) begin
                  w_row  = r_row + 5'd1;
                  w_next = S_DISP_REQ;
               end else begin
                  w_row  = '0;
                  w_next = S_DONE;
               end
            end
         end
         S_DONE: begin
            w_done = 1'b1;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_row   <= '0;
         r_slot  <= '0;
         r_sum   <= '0;
         r_out   <= '0;
         r_in    <= '0;
         r_cond  <= '0;
         r_add   <= '0;
         r_bdd   <= '0;
      end else begin
         r_state <= w_next;
         r_row   <= w_row;
         r_slot  <= w_slot;
         r_sum   <= w_sum;
         r_out   <= w_out;
         r_in    <= w_in;
         r_cond  <= w_cond;
         r_add   <= w_add;
         r_bdd   <= w_bdd;
      end
   end

   assign m.arw       = w_arw;
   assign m.brw       = w_brw;
   assign m.crw       = w_crw;
   assign m.add1      = w_add[0];
   assign m.add2      = w_add[1];
   assign m.add3      = w_add[2];
   assign m.bdd1      = w_bdd[0];
   assign m.bdd2      = w_bdd[1];
   assign m.bdd3      = w_bdd[2];
   assign m.cond      = w_cond;
   assign m.IN        = w_in;
   assign m.in_ready  = w_in_ready;
   assign m.out_valid = w_out_valid;
   assign m.out_data  = r_out;
   assign m.done      = w_done;
   assign m.busy      = (r_state != S_IDLE);
endmodule

// File: tb/tb_mem_sequencer.sv
// Bench for mem_sequencer: memory model, stream drivers, row-sum model.
// Build with +define+MEM_SEQ_SAT_EN to check the saturating variant.
module tb_mem_sequencer;
   localparam int NR = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   mem_sequencer_if bus ();

   mem_sequencer #(.N(NR)) dut (
      .clk (clk),
      .rst (rst),
      .m   (bus)
   );

   int errs   = 0;
   int checks = 0;
   int cyc    = 0;
   int omode  = 0;
   int hold   = 0;

   logic [7:0]  ma [3][32];
   logic [7:0]  mb [3][32];
   logic [7:0]  mc [32];
   logic [7:0]  rowb [NR][6];
   logic [31:0] wlog [$];
   logic [7:0]  olog [$];

   task automatic chk(input string nm, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%0h expected=%0h t=%0t", nm, got, exp, $time);
      end
   endtask

   task automatic fail_now(input string nm);
      checks++;
      errs++;
      $display("FAIL %s got=timeout expected=event t=%0t", nm, $time);
   endtask

   function automatic logic [7:0] sat8(input int s);
`ifdef MEM_SEQ_SAT_EN
      return (s > 255) ? 8'hFF : 8'(s);
`else
      return 8'(s % 256);
`endif
   endfunction

   function automatic logic [7:0] exp_sum(input int r);
      int s = 0;
      for (int i = 0; i < 6; i++) s += int'(rowb[r][i]);
      return sat8(s);
   endfunction

   always @(posedge clk) cyc++;

   // memory_module: per-slot memories, one-cycle read latency
   always @(posedge clk) begin
      if (bus.arw == 2'b10) begin
         ma[0][bus.add1] <= bus.IN;
         ma[1][bus.add2] <= bus.IN;
         ma[2][bus.add3] <= bus.IN;
      end
      if (bus.brw == 2'b10) begin
         mb[0][bus.bdd1] <= bus.IN;
         mb[1][bus.bdd2] <= bus.IN;
         mb[2][bus.bdd3] <= bus.IN;
      end
      if (bus.crw == 2'b10) mc[bus.cond] <= bus.IN;
      if (bus.arw == 2'b11) begin
         bus.a_1 <= ma[0][bus.add1];
         bus.a_2 <= ma[1][bus.add2];
         bus.a_3 <= ma[2][bus.add3];
      end
      if (bus.brw == 2'b11) begin
         bus.b_1 <= mb[0][bus.bdd1];
         bus.b_2 <= mb[1][bus.bdd2];
         bus.b_3 <= mb[2][bus.bdd3];
      end
      if (bus.crw == 2'b11) bus.dis_out <= mc[bus.cond];
   end

   // display sink: 0 always ready, 1 random, 2 three stall cycles per byte
   always @(posedge clk) begin
      #1;
      if (omode == 0) begin
         bus.out_ready = 1'b1;
      end else if (omode == 1) begin
         bus.out_ready = 1'($urandom_range(1));
      end else if (bus.out_valid) begin
         if (hold == 3) begin
            bus.out_ready = 1'b1;
            hold = 0;
         end else begin
            bus.out_ready = 1'b0;
            hold++;
         end
      end else begin
         bus.out_ready = 1'b0;
         hold = 0;
      end
   end

   // compare process
   int         lcnt = 0, ocnt = 0;
   logic       pv = 1'b0, pr = 1'b0;
   logic [7:0] pd = 8'h0;
   always @(negedge clk) begin
      if (!rst) begin
         lcnt = 0;
         ocnt = 0;
         pv   = 1'b0;
      end else begin
         if (bus.in_valid && bus.in_ready) begin
            int r, s;
            logic [4:0]  e [3];
            logic [31:0] got, exp;
            logic        ab;
            r  = lcnt / 6;
            s  = lcnt % 6;
            ab = (s < 3);
            for (int i = 0; i < 3; i++)
               e[i] = (i == s % 3) ? 5'(r) : 5'd31;
            got = ab ? {3'b0, bus.arw, bus.brw, bus.crw,
                        bus.add1, bus.add2, bus.add3, bus.IN}
                     : {3'b0, bus.arw, bus.brw, bus.crw,
                        bus.bdd1, bus.bdd2, bus.bdd3, bus.IN};
            exp = {3'b0, ab ? 2'b10 : 2'b00, ab ? 2'b00 : 2'b10,
                   2'b00, e[0], e[1], e[2], bus.in_data};
            if (r < NR) begin
               chk("load_wr", got, exp);
               rowb[r][s] = bus.in_data;
            end else begin
               chk("load_extra", lcnt, 6 * NR - 1);
            end
            wlog.push_back({3'b0, bus.arw, bus.brw, bus.crw,
                            bus.add1, bus.add2, bus.add3, bus.IN});
            lcnt++;
         end else if (bus.in_ready) begin
            chk("load_idle", {bus.arw, bus.brw, bus.crw}, 0);
         end
         if (pv && !pr)
            chk("out_hold", {bus.out_valid, bus.out_data}, {1'b1, pd});
         if (bus.out_valid && bus.out_ready) begin
            if (ocnt < NR) chk("out_data", bus.out_data, exp_sum(ocnt));
            else           chk("out_extra", ocnt, NR - 1);
            olog.push_back(bus.out_data);
            ocnt++;
         end
         if (bus.done) begin
            chk("done_counts", {16'(lcnt), 16'(ocnt)},
                {16'(6 * NR), 16'(NR)});
            lcnt = 0;
            ocnt = 0;
         end
         pv = bus.out_valid;
         pr = bus.out_ready;
         pd = bus.out_data;
      end
   end

   task automatic chk_rst(input string nm);
      chk({nm, "_addr"}, {bus.add1, bus.add2, bus.add3, bus.bdd1,
                          bus.bdd2, bus.bdd3, bus.cond}, 0);
      chk({nm, "_ctl"}, {bus.arw, bus.brw, bus.crw, bus.IN,
                         bus.out_data, bus.in_ready, bus.out_valid,
                         bus.busy, bus.done}, 0);
   endtask

   task automatic run(input logic [7:0] b[$], input int gap,
                      input int mode, input int kick, input int abort,
                      output int lat);
      int   n, t0, s;
      logic xf;
      lat = -1;
      olog.delete();
      wlog.delete();
      omode = mode;
      @(posedge clk);
      #1;
      bus.start = 1'b1;
      t0 = cyc;
      foreach (b[i]) begin
         bus.in_data = b[i];
         if (i == kick) bus.start = 1'b1;
         n  = 0;
         xf = 1'b0;
         do begin
            bus.in_valid = ($urandom_range(99) >= gap) || (n > 5);
            @(negedge clk);
            xf = bus.in_valid && bus.in_ready;
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            n++;
         end while (!xf && n < 300);
         if (!xf) begin
            fail_now("load_timeout");
            bus.in_valid = 1'b0;
            return;
         end
         if (i + 1 == abort) begin
            bus.in_valid = 1'b0;
            rst = 1'b0;
            return;
         end
      end
      n = 0;
      forever begin
         @(negedge clk);
         if (bus.done) break;
         if (++n > 500) begin
            fail_now("done_timeout");
            bus.in_valid = 1'b0;
            return;
         end
         bus.in_valid = 1'($urandom_range(1));
      end
      lat = cyc - t0;
      bus.start    = 1'b1;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.start    = 1'b0;
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("after_done", {bus.busy, bus.done, bus.in_ready}, 0);
      for (int r = 0; r < NR; r++) begin
         s = 0;
         for (int k = 0; k < 6; k++) s += int'(b[6 * r + k]);
         chk("sum_mem", mc[r], sat8(s));
      end
   endtask

   initial begin
      logic [7:0] q[$];
      int         lat;
      bus.start    = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h0;
      for (int i = 0; i < 32; i++) begin
         mc[i] = 8'h0;
         for (int j = 0; j < 3; j++) begin
            ma[j][i] = 8'h0;
            mb[j][i] = 8'h0;
         end
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk_rst("por");
      @(posedge clk);
      #1;
      rst = 1'b1;

      q = {};
      for (int i = 1; i <= 6 * NR; i++) q.push_back(8'(i));
      run(q, 0, 0, -1, -1, lat);
      chk("lat_fast", lat, 12 * NR + 1);
      chk("out0_lit", (olog.size() > 0) ? olog[0] : 8'h0, 8'd21);
      chk("out1_lit", (olog.size() > 1) ? olog[1] : 8'h0, 8'd57);
      chk("a2_load_lit", (wlog.size() > 1) ? wlog[1] : 32'h0,
          {3'b0, 2'b10, 2'b00, 2'b00, 5'd31, 5'd0, 5'd31, 8'h02});

      q = {};
      for (int i = 0; i < 6 * NR; i++) q.push_back(8'hFF);
      run(q, 0, 2, -1, -1, lat);
      chk("lat_stall", lat, 15 * NR + 1);
`ifdef MEM_SEQ_SAT_EN
      chk("ff_lit", (olog.size() > 0) ? olog[0] : 8'h0, 8'hFF);
`else
      chk("ff_lit", (olog.size() > 0) ? olog[0] : 8'h0, 8'hFA);
`endif

      q = {};
      for (int i = 0; i < 6 * NR; i++) q.push_back(8'($urandom_range(255)));
      run(q, 0, 0, 3, 5, lat);
      @(negedge clk);
      chk_rst("midrst");
      @(posedge clk);
      #1;
      rst = 1'b1;
      q = {};
      for (int i = 0; i < 6 * NR; i++) q.push_back(8'($urandom_range(255)));
      run(q, 0, 0, -1, -1, lat);
      chk("lat_fresh", lat, 12 * NR + 1);

      for (int k = 0; k < 8; k++) begin
         q = {};
         for (int i = 0; i < 6 * NR; i++)
            q.push_back(8'($urandom_range(255)));
         run(q, 30, 1, -1, -1, lat);
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
